// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-FF synchroniser, tick-based debouncer and press-pulse generator.
// Optional auto-repeat of press pulses while held, enabled by defining BUTTON_REPEAT_EN.
`default_nettype none

module button_conditioner #(
    parameter int N            = 4,
    parameter int STABLE_TICKS = 3,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         tick,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press
);

    localparam int            CW     = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] r_level;
    logic [N-1:0] r_press;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [CW-1:0] r_cnt;
        logic          w_diff;
        logic          w_qual;
        logic          w_rise;
        logic          w_fall;
        logic          w_rep_pulse;

        assign w_diff = r_sync2[i] ^ r_level[i];
        assign w_qual = tick & w_diff & (r_cnt == C_LAST);
        assign w_rise = w_qual & r_sync2[i];
        assign w_fall = w_qual & ~r_sync2[i];

        // Any return of sync to the current level restarts qualification, tick or not.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_cnt      <= '0;
                r_level[i] <= 1'b0;
            end else if (!w_diff) begin
                r_cnt <= '0;
            end else if (tick) begin
                if (r_cnt == C_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

`ifdef BUTTON_REPEAT_EN
        localparam int            RW       = $clog2(REPEAT_DELAY + 1);
        localparam logic [RW-1:0] C_RHIT   = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] C_RELOAD = RW'(REPEAT_DELAY - REPEAT_RATE);

        logic [RW-1:0] r_rep;

        // A release qualifying on this edge suppresses the repeat pulse on the same edge.
        assign w_rep_pulse = tick & r_level[i] & ~w_fall & (r_rep == C_RHIT);

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_rep <= '0;
            end else if (!r_level[i] || w_fall) begin
                r_rep <= '0;
            end else if (tick) begin
                if (r_rep == C_RHIT) begin
                    r_rep <= C_RELOAD;
                end else begin
                    r_rep <= r_rep + 1'b1;
                end
            end
        end
`else
        assign w_rep_pulse = 1'b0;
`endif

        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_press[i] <= 1'b0;
            end else begin
                r_press[i] <= w_rise | w_rep_pulse;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_press;

endmodule

`default_nettype wire
